// File: rtl/fp_pkg.sv
// Shared widths, limits and FSM encoding for the single-precision adder normalizer.
// Pure declarations: no latency or backpressure of its own.
package fp_pkg;
  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int STAGES  = 5;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 3;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_e;
endpackage

// File: rtl/fp_normalizer_if.sv
// Operand/result handshake bundle for the normalizer; master drives operands and sinks results.
// Valid/ready on both sides; a result holds until out_ready is seen.
interface fp_normalizer_if;
  import fp_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MANT_W:0]     in_mant;
  logic [EXP_W-1:0]    in_exp;
  logic                out_valid;
  logic                out_ready;
  logic [MANT_W-1:0]   out_mant;
  logic [EXP_W-1:0]    out_exp;
  logic [SHIFT_W-1:0]  out_shift;
  logic                out_zero;
  logic                out_ovf;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_ovf
  );
endinterface

// File: rtl/fp_norm_step.sv
// One log-step of the left normalizer: shift by step if the top bits are clear and exp stays >= 1.
// Purely combinational, no handshake.
module fp_norm_step
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0]  mant,
  input  logic [EXP_W-1:0]   exp,
  input  logic [SHIFT_W-1:0] step,
  output logic [MANT_W-1:0]  mant_nxt,
  output logic [EXP_W-1:0]   exp_nxt,
  output logic               take
);
  logic [MANT_W-1:0] top_mask;
  logic [EXP_W-1:0]  step_e;

  always_comb begin
    top_mask = ~({MANT_W{1'b1}} >> step);
    step_e   = EXP_W'(step);
    take     = ((mant & top_mask) == '0) && (exp > step_e);
    mant_nxt = take ? (mant << step) : mant;
    exp_nxt  = take ? (exp - step_e) : exp;
  end
endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalizer: carry/zero/overflow handling, 16-8-4-2-1 left shift, denormal fixup.
// Result valid 6 edges after accept; one op in flight, result held while out_ready is low.
module fp_normalizer
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp_normalizer_if.slave io
);
  norm_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fix_q, fix_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [MANT_W-1:0]  out_mant_q, out_mant_d;
  logic [EXP_W-1:0]   out_exp_q, out_exp_d;
  logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
  logic               out_zero_q, out_zero_d;
  logic               out_ovf_q, out_ovf_d;

  logic [SHIFT_W-1:0] step;
  logic [MANT_W-1:0]  mant_nxt;
  logic [EXP_W-1:0]   exp_nxt;
  logic               take;

  assign step = SHIFT_W'(1) << cnt_q;

  fp_norm_step u_step (
    .mant     (mant_q),
    .exp      (exp_q),
    .step     (step),
    .mant_nxt (mant_nxt),
    .exp_nxt  (exp_nxt),
    .take     (take)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fix_d       = fix_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sh_d        = sh_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_shift_d = out_shift_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(STAGES - 1);
          fix_d   = 1'b0;
          sh_d    = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          if (io.in_mant == '0) begin
            zero_d = 1'b1;
            mant_d = '0;
            exp_d  = '0;
          end else if (io.in_mant[MANT_W]) begin
            if (io.in_exp >= EXP_MAX - 8'd1) begin
              ovf_d  = 1'b1;
              mant_d = '0;
              exp_d  = EXP_MAX;
            end else begin
              mant_d = io.in_mant[MANT_W:1];
              exp_d  = io.in_exp + 8'd1;
            end
          end else begin
            mant_d = io.in_mant[MANT_W-1:0];
            exp_d  = io.in_exp;
          end
        end
      end
      SHIFT: begin
        if (fix_q) begin
          state_d     = DONE;
          fix_d       = 1'b0;
          cnt_d       = CNT_W'(STAGES - 1);
          out_mant_d  = mant_q;
          out_shift_d = sh_q;
          out_zero_d  = zero_q;
          out_ovf_d   = ovf_q;
          // Unshiftable leftovers become denormals; a hidden bit at exp 0 means the sum went normal.
          if (ovf_q)                   out_exp_d = EXP_MAX;
          else if (zero_q)             out_exp_d = '0;
          else if (!mant_q[MANT_W-1])  out_exp_d = '0;
          else if (exp_q == '0)        out_exp_d = 8'd1;
          else                         out_exp_d = exp_q;
        end else begin
          // An overflowed op carries a zero mantissa with exp 0xFF and must not be shifted.
          if (take && !ovf_q) begin
            mant_d = mant_nxt;
            exp_d  = exp_nxt;
            sh_d   = sh_q + step;
          end
          if (cnt_q == '0) fix_d = 1'b1;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_W'(STAGES - 1);
      fix_q       <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      sh_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fix_q       <= fix_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sh_q        <= sh_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_shift_q <= out_shift_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_mant  = out_mant_q;
  assign io.out_exp   = out_exp_q;
  assign io.out_shift = out_shift_q;
  assign io.out_zero  = out_zero_q;
  assign io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized bench for fp_normalizer against an arithmetic model of the normalization rules.
module tb_fp_normalizer;
  import fp_pkg::*;

  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [4:0]  shift;
    logic        zero;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_normalizer_if f();

  fp_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (f)
  );

  int   tests = 0;
  int   fails = 0;
  res_t expq[$];
  res_t act_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Normalized shift is min(leading zeros, exp-1), never negative.
  function automatic res_t model(input logic [24:0] m, input logic [7:0] e);
    res_t        r;
    int          lz, lim, sh;
    logic [23:0] mm;
    r = '0;
    if (m == 25'd0) begin
      r.zero = 1'b1;
    end else if (m[24]) begin
      if (e >= 8'hFE) begin
        r.ovf = 1'b1;
        r.exp = 8'hFF;
      end else begin
        r.mant = m[24:1];
        r.exp  = e + 8'd1;
      end
    end else begin
      mm = m[23:0];
      lz = 0;
      for (int i = 23; i >= 0; i--) begin
        if (mm[i]) break;
        lz++;
      end
      lim     = (e == 8'd0) ? 0 : int'(e) - 1;
      sh      = (lz < lim) ? lz : lim;
      r.mant  = mm << sh;
      r.shift = 5'(sh);
      r.exp   = e - 8'(sh);
      if (!r.mant[23])          r.exp = 8'd0;
      else if (r.exp == 8'd0)   r.exp = 8'd1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && f.out_valid === 1'b1) begin
      act_r = {f.out_mant, f.out_exp, f.out_shift, f.out_zero, f.out_ovf};
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h with no op outstanding (t=%0t)", act_r, $time);
      end else begin
        chk("result", act_r, expq[0]);
        chk("in_ready_in_done", f.in_ready, 1'b0);
        if (f.out_ready === 1'b1) void'(expq.pop_front());
      end
    end
  end

  task automatic send(input logic [24:0] m, input logic [7:0] e, input int hold);
    int n, lat;
    n = 0;
    while (f.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", f.in_ready, 1'b1);
    f.in_mant  = m;
    f.in_exp   = e;
    f.in_valid = 1'b1;
    @(posedge clk);
    expq.push_back(model(m, e));
    #1;
    lat = 0;
    // Garbage operands while busy must be ignored.
    while (f.out_valid !== 1'b1 && lat < 50) begin
      f.in_valid = 1'($urandom_range(0, 1));
      f.in_mant  = 25'($urandom);
      f.in_exp   = 8'($urandom);
      @(posedge clk); #1; lat++;
    end
    f.in_valid = 1'b0;
    chk("latency", lat, 6);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    f.out_ready = 1'b1;
    @(posedge clk); #1;
    f.out_ready = 1'b0;
    chk("out_valid_after_handshake", f.out_valid, 1'b0);
    chk("in_ready_after_handshake", f.in_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, f.out_valid, 1'b0);
    chk({tag, "_in_ready"}, f.in_ready, 1'b1);
    chk({tag, "_outputs"}, {f.out_mant, f.out_exp, f.out_shift, f.out_zero, f.out_ovf}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] m;
    logic [7:0]  e;

    rst_n      = 1'b0;
    f.in_valid = 1'b0;
    f.in_mant  = '0;
    f.in_exp   = '0;
    f.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed anchors for the model.
    chk("model_plain",  model(25'h0800000, 8'h80), {24'h800000, 8'h80, 5'd0, 1'b0, 1'b0});
    chk("model_carry",  model(25'h1800001, 8'h80), {24'hC00000, 8'h81, 5'd0, 1'b0, 1'b0});
    chk("model_full",   model(25'h0000001, 8'h80), {24'h800000, 8'h69, 5'd23, 1'b0, 1'b0});
    chk("model_clamp",  model(25'h0000100, 8'h05), {24'h001000, 8'h00, 5'd4, 1'b0, 1'b0});
    chk("model_ovf",    model(25'h1000000, 8'hFE), {24'h000000, 8'hFF, 5'd0, 1'b0, 1'b1});
    chk("model_zero",   model(25'h0000000, 8'h40), {24'h000000, 8'h00, 5'd0, 1'b1, 1'b0});
    chk("model_den_in", model(25'h0800000, 8'h00), {24'h800000, 8'h01, 5'd0, 1'b0, 1'b0});

    send(25'h0800000, 8'h80, 3);
    send(25'h1800001, 8'h80, 0);
    send(25'h0000001, 8'h80, 1);
    send(25'h0000100, 8'h05, 0);
    send(25'h1000000, 8'hFE, 2);
    send(25'h0000000, 8'h40, 0);
    send(25'h1FFFFFF, 8'hFF, 0);
    send(25'h0000003, 8'h01, 0);
    send(25'h0800000, 8'h00, 1);

    // Reset while stage 2 is pending: op dropped, block idle at once.
    f.in_mant  = 25'h0000001;
    f.in_exp   = 8'h80;
    f.in_valid = 1'b1;
    @(posedge clk); #1;
    f.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_shift");
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(25'h0000100, 8'h05, 0);

    // Reset while a result is held in DONE.
    f.in_mant  = 25'h1800001;
    f.in_exp   = 8'h80;
    f.in_valid = 1'b1;
    @(posedge clk);
    expq.push_back(model(25'h1800001, 8'h80));
    #1;
    f.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("held_before_reset", f.out_valid, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_done");
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(25'h0000001, 8'h80, 0);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 5))
        0:       m = 25'd0;
        1:       m = {1'b1, 24'($urandom)};
        2:       m = 25'(24'($urandom) >> $urandom_range(0, 23));
        3:       m = 25'd1 << $urandom_range(0, 24);
        default: m = 25'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 30));
        1:       e = 8'($urandom_range(253, 255));
        default: e = 8'($urandom);
      endcase
      send(m, e, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
